// File: rtl/fp_minmax_reduce.sv
// ============================================================================
// Module   : fp_minmax_reduce
// Purpose  : Streaming fp32 packet reduction emitting min, max, beat and NaN
//            counts once the last beat of a packet is accepted.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_minmax_reduce #(
  parameter int CNT_W = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_min,
  output logic [31:0]      m_max,
  output logic [CNT_W-1:0] m_count,
  output logic [CNT_W-1:0] m_nan_count,
  output logic             m_empty
);

  localparam logic [31:0]      c_qnan    = 32'h7FC0_0000;
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  state_t           r_state;
  logic [31:0]      r_acc_min;
  logic [31:0]      r_acc_max;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_nan_cnt;

  logic             w_accept;
  logic             w_is_nan;
  logic             w_have_n;
  logic [31:0]      w_min_n;
  logic [31:0]      w_max_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic [CNT_W-1:0] w_nan_n;

  function automatic logic f_is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  function automatic logic f_le(input logic [31:0] a, input logic [31:0] b);
    if (f_is_nan(a) || f_is_nan(b)) return 1'b0;
    if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) return 1'b1;
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] <= b[30:0];
    return a[30:0] >= b[30:0];
  endfunction

  assign s_ready  = !m_valid || m_ready;
  assign w_accept = s_valid && s_ready;
  assign w_is_nan = f_is_nan(s_data);

  // Accumulator view after folding in the current beat, shared by the
  // normal update path and the end-of-packet result load.
  always_comb begin
    w_have_n = (r_state == S_ACCUM);
    w_min_n  = r_acc_min;
    w_max_n  = r_acc_max;
    w_cnt_n  = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;
    w_nan_n  = r_nan_cnt;
    if (w_is_nan) begin
      w_nan_n = (r_nan_cnt == c_cnt_max) ? r_nan_cnt : r_nan_cnt + 1'b1;
    end else if (r_state == S_IDLE) begin
      w_have_n = 1'b1;
      w_min_n  = s_data;
      w_max_n  = s_data;
    end else begin
      if (!f_le(r_acc_min, s_data)) w_min_n = s_data;
      if (!f_le(s_data, r_acc_max)) w_max_n = s_data;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= S_IDLE;
      r_acc_min   <= 32'd0;
      r_acc_max   <= 32'd0;
      r_cnt       <= '0;
      r_nan_cnt   <= '0;
      m_valid     <= 1'b0;
      m_min       <= 32'd0;
      m_max       <= 32'd0;
      m_count     <= '0;
      m_nan_count <= '0;
      m_empty     <= 1'b0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (w_accept && s_last) begin
        m_valid     <= 1'b1;
        m_min       <= w_have_n ? w_min_n : c_qnan;
        m_max       <= w_have_n ? w_max_n : c_qnan;
        m_count     <= w_cnt_n;
        m_nan_count <= w_nan_n;
        m_empty     <= !w_have_n;
        r_state     <= S_IDLE;
        r_acc_min   <= 32'd0;
        r_acc_max   <= 32'd0;
        r_cnt       <= '0;
        r_nan_cnt   <= '0;
      end else if (w_accept) begin
        r_state   <= w_have_n ? S_ACCUM : S_IDLE;
        r_acc_min <= w_min_n;
        r_acc_max <= w_max_n;
        r_cnt     <= w_cnt_n;
        r_nan_cnt <= w_nan_n;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_minmax_reduce.sv
// ============================================================================
// Module   : tb_fp_minmax_reduce
// Purpose  : Directed self-checking bench for fp_minmax_reduce.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_minmax_reduce;

  localparam int CNT_W = 16;

  logic             aclk;
  logic             aresetn;
  logic             s_valid;
  logic             s_ready;
  logic [31:0]      s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [31:0]      m_min;
  logic [31:0]      m_max;
  logic [CNT_W-1:0] m_count;
  logic [CNT_W-1:0] m_nan_count;
  logic             m_empty;

  int total;
  int bad;

  fp_minmax_reduce #(.CNT_W(CNT_W)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_min       (m_min),
    .m_max       (m_max),
    .m_count     (m_count),
    .m_nan_count (m_nan_count),
    .m_empty     (m_empty)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] mn, input logic [31:0] mx,
                              input int cnt, input int nan, input logic empty);
    check({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
    check({tag, "_min"},   m_min, mn);
    check({tag, "_max"},   m_max, mx);
    check({tag, "_count"}, {16'd0, m_count}, cnt);
    check({tag, "_nan"},   {16'd0, m_nan_count}, nan);
    check({tag, "_empty"}, {31'd0, m_empty}, {31'd0, empty});
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] d, input logic last);
    bit done;
    done    = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int i = 0; i < 50 && !done; i++) begin
      done = s_ready;
      @(posedge aclk);
      #1;
    end
    total++;
    assert (done) else begin
      bad++;
      $error("FAIL send_timeout observed=0 expected=1");
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    aresetn = 1'b0;
    s_valid = 1'b0;
    s_data  = 32'd0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    #12;
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_min", m_min, 32'd0);
    check("rst_max", m_max, 32'd0);
    check("rst_count", {16'd0, m_count}, 32'd0);
    check("rst_nan", {16'd0, m_nan_count}, 32'd0);
    check("rst_empty", {31'd0, m_empty}, 32'd0);
    check("rst_ready", {31'd0, s_ready}, 32'd1);
    aresetn = 1'b1;
    tick();

    // mixed signs: 1.5, 2.5, -1.0
    send(32'h3FC0_0000, 1'b0);
    send(32'h4020_0000, 1'b0);
    send(32'hBF80_0000, 1'b1);
    check_result("t1", 32'hBF80_0000, 32'h4020_0000, 3, 0, 1'b0);
    tick();
    check("t1_drain", {31'd0, m_valid}, 32'd0);

    // NaNs around a single real value
    send(32'h7FC0_0001, 1'b0);
    send(32'h3F80_0000, 1'b0);
    send(32'h7F80_0001, 1'b1);
    check_result("t2", 32'h3F80_0000, 32'h3F80_0000, 3, 2, 1'b0);
    tick();

    // -0 then +0: tie keeps the first element
    send(32'h8000_0000, 1'b0);
    send(32'h0000_0000, 1'b1);
    check_result("t3", 32'h8000_0000, 32'h8000_0000, 2, 0, 1'b0);
    tick();

    // single-beat packet, -inf; valid for exactly one cycle
    check("t4_pre", {31'd0, m_valid}, 32'd0);
    send(32'hFF80_0000, 1'b1);
    check_result("t4", 32'hFF80_0000, 32'hFF80_0000, 1, 0, 1'b0);
    tick();
    check("t4_post", {31'd0, m_valid}, 32'd0);

    // all-NaN packet, then a back-to-back last beat during the drain
    send(32'h7FC0_0000, 1'b0);
    send(32'hFFC0_0001, 1'b1);
    check_result("nan", 32'h7FC0_0000, 32'h7FC0_0000, 2, 2, 1'b1);
    send(32'h4200_0000, 1'b1);
    check_result("b2b", 32'h4200_0000, 32'h4200_0000, 1, 0, 1'b0);
    tick();

    // backpressure: A held while B waits
    m_ready = 1'b0;
    send(32'h4040_0000, 1'b0);
    send(32'hC000_0000, 1'b1);
    check_result("t5a", 32'hC000_0000, 32'h4040_0000, 2, 0, 1'b0);
    s_valid = 1'b1;
    s_data  = 32'h3F80_0000;
    s_last  = 1'b0;
    #1;
    check("t5_stall", {31'd0, s_ready}, 32'd0);
    tick();
    tick();
    tick();
    check_result("t5hold", 32'hC000_0000, 32'h4040_0000, 2, 0, 1'b0);
    m_ready = 1'b1;
    #1;
    check("t5_ready", {31'd0, s_ready}, 32'd1);
    send(32'h3F80_0000, 1'b0);
    check("t5_drained", {31'd0, m_valid}, 32'd0);
    send(32'hBF00_0000, 1'b1);
    check_result("t5b", 32'hBF00_0000, 32'h3F80_0000, 2, 0, 1'b0);
    tick();

    // reset mid-packet discards the partial packet
    send(32'h4100_0000, 1'b0);
    send(32'h4110_0000, 1'b0);
    #2;
    aresetn = 1'b0;
    #3;
    check("t6_rst_valid", {31'd0, m_valid}, 32'd0);
    aresetn = 1'b1;
    tick();
    tick();
    check("t6_no_valid", {31'd0, m_valid}, 32'd0);
    send(32'h4000_0000, 1'b1);
    check_result("t6", 32'h4000_0000, 32'h4000_0000, 1, 0, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
